// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap2_pkg
//  Purpose  : Shared constants and state encoding for the SAP2 program loader
//  Revision : 1.0  initial release
// ============================================================================
package sap2_pkg;

  // Default RAM geometry of the SAP2 mini core
  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 12;
  localparam int RAM_DEPTH = 256;

  // Loader state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_FLUSH = ST_FLUSH,
    S_CLEAR = ST_CLEAR,
    S_RUN   = ST_RUN
  } state_t;

  // States in which the loader owns the core (busy indication)
  function automatic logic is_busy(state_t s);
    return (s == S_LOAD) || (s == S_FLUSH) || (s == S_CLEAR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_if
//  Purpose  : Valid/ready word stream from the host bridge into the loader
//  Revision : 1.0  initial release
// ============================================================================
interface prog_loader_if #(
  parameter int DW = 12
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  // Host-side word source
  modport master (output s_valid, output s_data, input s_ready);
  // Loader side
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/prog_loader_load_counter.sv
`default_nettype none
// ============================================================================
//  Module   : load_counter
//  Purpose  : Base/remaining-count registers, wrapping write address and
//             last-beat flag for a load session
//  Revision : 1.0  initial release
// ============================================================================
module load_counter #(
  parameter int AW = 8
) (
  input  wire logic          clk,
  input  wire logic          clr,
  input  wire logic          load,
  input  wire logic          step,
  input  wire logic [AW-1:0] base,
  input  wire logic [AW:0]   count,
  output logic      [AW-1:0] addr,
  output logic               last
);

  // Largest session covers the whole RAM exactly once
  localparam logic [AW:0] c_max_count = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] c_one       = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] r_addr;
  logic [AW:0]   r_remaining;
  logic [AW:0]   w_clamped;

  assign w_clamped = (count > c_max_count) ? c_max_count : count;

  // Latch base/count on session start, advance (with natural wrap) per beat
  always_ff @(posedge clk) begin
    if (clr) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (load) begin
      r_addr      <= base;
      r_remaining <= w_clamped;
    end else if (step) begin
      r_addr      <= r_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign addr = r_addr;
  assign last = (r_remaining == c_one);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Streams program words into the SAP2 RAM via prog/a/d, holds the
//             CPU in clear while loading, then releases it and reports status
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader
  import sap2_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int CLR_CYCLES = 2
) (
  input  wire logic          clk,
  input  wire logic          clr,
  input  wire logic          start,
  input  wire logic [AW-1:0] base,
  input  wire logic [AW:0]   count,
  prog_loader_if.slave       stream,
  output logic               prog,
  output logic      [AW-1:0] a,
  output logic      [DW-1:0] d,
  output logic               cpu_clr,
  input  wire logic          hlt,
  output logic               busy,
  output logic               done,
  output logic               running,
  output logic               halted
);

  localparam int c_cw = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t          r_state, w_next;
  logic [c_cw-1:0] r_clr_cnt;
  logic            r_prog, r_cpu_clr, r_s_ready, r_busy, r_done;
  logic [AW-1:0]   r_a;
  logic [DW-1:0]   r_d;

  logic            w_prog_nxt, w_cpu_clr_nxt, w_s_ready_nxt, w_busy_nxt, w_done_nxt;
  logic [AW-1:0]   w_a_nxt;
  logic [DW-1:0]   w_d_nxt;
  logic            w_beat, w_kick, w_last;
  logic [AW-1:0]   w_addr;

  // A beat needs the registered ready, so ready never depends on valid
  assign w_beat = (r_state == S_LOAD) && stream.s_valid && r_s_ready;
  assign w_kick = start && ((r_state == S_IDLE) || (r_state == S_RUN));

  load_counter #(.AW(AW)) u_load_counter (
    .clk   (clk),
    .clr   (clr),
    .load  (w_kick),
    .step  (w_beat),
    .base  (base),
    .count (count),
    .addr  (w_addr),
    .last  (w_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and next registered output values
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN: if (start) w_next = (count != '0) ? S_LOAD : S_CLEAR;
      S_LOAD:        if (w_beat && w_last) w_next = S_FLUSH;
      S_FLUSH:       w_next = S_CLEAR;
      S_CLEAR:       if (r_clr_cnt == '0) w_next = S_RUN;
      default:       w_next = S_IDLE;
    endcase

    // prog rises only with the first accepted beat and stays up through FLUSH
    w_prog_nxt = 1'b0;
    if (w_next == S_FLUSH)     w_prog_nxt = 1'b1;
    else if (w_next == S_LOAD) w_prog_nxt = r_prog | w_beat;

    w_a_nxt       = w_beat ? w_addr : r_a;
    w_d_nxt       = w_beat ? stream.s_data : r_d;
    w_cpu_clr_nxt = (w_next != S_RUN);
    w_s_ready_nxt = (w_next == S_LOAD);
    w_busy_nxt    = is_busy(w_next);
    w_done_nxt    = (w_next == S_RUN) && (r_state != S_RUN);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      r_prog    <= 1'b0;
      r_a       <= '0;
      r_d       <= '0;
      r_cpu_clr <= 1'b1;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_prog    <= w_prog_nxt;
      r_a       <= w_a_nxt;
      r_d       <= w_d_nxt;
      r_cpu_clr <= w_cpu_clr_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // CLEAR dwell counter, preset on entry and counted down to zero
  always_ff @(posedge clk) begin
    if (clr) begin
      r_clr_cnt <= '0;
    end else if ((w_next == S_CLEAR) && (r_state != S_CLEAR)) begin
      r_clr_cnt <= c_cw'(CLR_CYCLES - 1);
    end else if ((r_state == S_CLEAR) && (r_clr_cnt != '0)) begin
      r_clr_cnt <= r_clr_cnt - 1'b1;
    end
  end

  assign prog           = r_prog;
  assign a              = r_a;
  assign d              = r_d;
  assign cpu_clr        = r_cpu_clr;
  assign stream.s_ready = r_s_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign running        = (r_state == S_RUN) && !hlt;
  assign halted         = (r_state == S_RUN) && hlt;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader with a RAM model and a
//             behavioural expectation of RAM contents and session timing
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

  localparam int CLRC = 2;

  logic        clk = 1'b0;
  logic        clr, start, hlt;
  logic [7:0]  base;
  logic [8:0]  count;
  logic        prog, cpu_clr, busy, done, running, halted;
  logic [7:0]  a;
  logic [11:0] d;

  prog_loader_if #(.DW(12)) sif ();

  prog_loader #(.AW(8), .DW(12), .CLR_CYCLES(CLRC)) dut (
    .clk (clk), .clr (clr), .start (start), .base (base), .count (count),
    .stream (sif.slave), .prog (prog), .a (a), .d (d), .cpu_clr (cpu_clr),
    .hlt (hlt), .busy (busy), .done (done), .running (running), .halted (halted)
  );

  always #5 clk = ~clk;

  // Core RAM behaviour: writes d to a on every edge while prog is high
  logic [11:0] ram     [256] = '{default: 12'h000};
  logic [11:0] exp_ram [256] = '{default: 12'h000};
  int          wr_addr [$];
  always @(posedge clk) if (prog) begin
    ram[a] <= d;
    wr_addr.push_back(int'(a));
  end

  logic [11:0] words [$];
  int checks = 0;
  int passes = 0;

  // Spec-level model: session of c words from base b lands at (b+k) mod 256
  function automatic int eff_count(input int c);
    return (c > 256) ? 256 : c;
  endfunction

  task automatic model_load(input int b, input int n);
    for (int k = 0; k < n; k++) exp_ram[(b + k) % 256] = words[k];
  endtask

  function automatic int ram_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) n++;
    return n;
  endfunction

  function automatic int stray_writes(input int b, input int n);
    int bad = 0;
    foreach (wr_addr[i]) if (((wr_addr[i] - b + 256) % 256) >= n) bad++;
    return bad;
  endfunction

  task automatic fill_words(input int n);
    words.delete();
    for (int k = 0; k < n; k++) words.push_back(12'($urandom));
  endtask

  // Issue start for one cycle; returns at the negedge after the start edge
  task automatic kick(input int b, input int c);
    @(negedge clk);
    start = 1'b1; base = b[7:0]; count = c[8:0]; sif.s_valid = 1'b0;
    wr_addr.delete();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed words until done is seen; edges counts from the start edge (=1)
  task automatic stream(input bit gapped, output int edges, output int acc,
                        output bit got_done, output bit early_prog, output bit clr_at_done);
    bit rdy;
    edges = 1; acc = 0; got_done = 0; early_prog = 0; clr_at_done = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done) begin
        got_done = 1; clr_at_done = cpu_clr;
        break;
      end
      if (acc == 0 && prog) early_prog = 1;
      sif.s_valid = (acc < words.size()) && (!gapped || cyc[0]);
      sif.s_data  = (acc < words.size()) ? words[acc] : 12'h000;
      rdy = sif.s_ready;
      @(posedge clk);
      edges++;
      if (sif.s_valid && rdy) acc++;
      @(negedge clk);
    end
    sif.s_valid = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b1; count = 9'd5; base = 8'h00; hlt = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({prog, cpu_clr, sif.s_ready, busy, done} !== 5'b01000)
      $display("FAIL reset_ctrl got %b want 01000", {prog, cpu_clr, sif.s_ready, busy, done}); else passes++;
    checks++; if ({a, d} !== 20'h0)
      $display("FAIL reset_ad got a=%h d=%h want 0/0", a, d); else passes++;
    checks++; if ({running, halted} !== 2'b00)
      $display("FAIL reset_status got %b want 00", {running, halted}); else passes++;
    start = 1'b0; clr = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)
      $display("FAIL clr_beats_start busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_back_to_back;
    int e, acc; bit gd, ep, cd;
    fill_words(4);
    kick(16, 4);
    stream(1'b0, e, acc, gd, ep, cd);
    model_load(16, 4);
    checks++; if (e !== 4 + 2 + CLRC)
      $display("FAIL b2b_latency got %0d edges want %0d (done seen=%0d)", e, 4 + 2 + CLRC, gd); else passes++;
    checks++; if (cd !== 1'b0)
      $display("FAIL b2b_cpu_clr_at_done got %b want 0", cd); else passes++;
    checks++; if (ram_diffs() !== 0)
      $display("FAIL b2b_ram got %0d bad words want 0", ram_diffs()); else passes++;
    @(negedge clk);
    checks++; if (done !== 1'b0)
      $display("FAIL b2b_done_width done got %b want 0", done); else passes++;
  endtask

  task automatic test_gapped;
    int e, acc; bit gd, ep, cd;
    int b = $urandom_range(0, 255);
    fill_words(3);
    kick(b, 3);
    stream(1'b1, e, acc, gd, ep, cd);
    model_load(b, 3);
    checks++; if (acc !== 3 || gd !== 1'b1)
      $display("FAIL gap_beats got %0d done=%0d want 3 done=1", acc, gd); else passes++;
    checks++; if (ep !== 1'b0)
      $display("FAIL gap_early_prog got %b want 0", ep); else passes++;
    checks++; if (stray_writes(b, 3) !== 0)
      $display("FAIL gap_stray got %0d stray writes want 0", stray_writes(b, 3)); else passes++;
    checks++; if (ram_diffs() !== 0)
      $display("FAIL gap_ram got %0d bad words want 0", ram_diffs()); else passes++;
  endtask

  task automatic test_wrap;
    int e, acc; bit gd, ep, cd;
    fill_words(4);
    kick(254, 4);
    stream(1'b0, e, acc, gd, ep, cd);
    model_load(254, 4);
    checks++; if (ram_diffs() !== 0)
      $display("FAIL wrap_ram got %0d bad words want 0", ram_diffs()); else passes++;
    checks++; if (wr_addr.size() < 4 || wr_addr[0] !== 254 || wr_addr[wr_addr.size()-1] !== 1)
      $display("FAIL wrap_order got first=%0d last=%0d want 254/1",
               (wr_addr.size() > 0) ? wr_addr[0] : -1,
               (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1); else passes++;
  endtask

  task automatic test_count_zero;
    int e, acc; bit gd, ep, cd;
    fill_words(2);
    kick(5, 0);
    stream(1'b0, e, acc, gd, ep, cd);
    checks++; if (e !== 1 + CLRC)
      $display("FAIL zero_latency got %0d edges want %0d", e, 1 + CLRC); else passes++;
    checks++; if (wr_addr.size() !== 0 || acc !== 0)
      $display("FAIL zero_no_write got %0d writes %0d beats want 0/0", wr_addr.size(), acc); else passes++;
  endtask

  task automatic test_count_clamp;
    int e, acc; bit gd, ep, cd;
    int b = $urandom_range(0, 255);
    fill_words(300);
    kick(b, 300);
    stream(1'b0, e, acc, gd, ep, cd);
    model_load(b, eff_count(300));
    checks++; if (acc !== 256)
      $display("FAIL clamp_beats got %0d want 256", acc); else passes++;
    checks++; if (e !== 256 + 2 + CLRC)
      $display("FAIL clamp_latency got %0d edges want %0d", e, 256 + 2 + CLRC); else passes++;
    checks++; if (ram_diffs() !== 0)
      $display("FAIL clamp_ram got %0d bad words want 0", ram_diffs()); else passes++;
    checks++; if (sif.s_ready !== 1'b0)
      $display("FAIL clamp_ready_after got %b want 0", sif.s_ready); else passes++;
  endtask

  task automatic test_run_halt;
    int e, acc; bit gd, ep, cd;
    int b = $urandom_range(0, 255);
    fill_words(5);
    words[4] = 12'hFF0;
    kick(b, 5);
    stream(1'b0, e, acc, gd, ep, cd);
    model_load(b, 5);
    checks++; if ({running, halted, cpu_clr} !== 3'b100)
      $display("FAIL run_status got %b want 100", {running, halted, cpu_clr}); else passes++;
    repeat (3) @(negedge clk);
    hlt = 1'b1;
    #1;
    checks++; if ({running, halted} !== 2'b01)
      $display("FAIL halt_status got %b want 01", {running, halted}); else passes++;
    fill_words(2);
    b = $urandom_range(0, 255);
    kick(b, 2);
    checks++; if ({cpu_clr, sif.s_ready, busy, halted} !== 4'b1110)
      $display("FAIL restart_ctrl got %b want 1110", {cpu_clr, sif.s_ready, busy, halted}); else passes++;
    hlt = 1'b0;
    stream(1'b0, e, acc, gd, ep, cd);
    model_load(b, 2);
    checks++; if (ram_diffs() !== 0 || e !== 2 + 2 + CLRC)
      $display("FAIL restart_load got %0d bad words %0d edges want 0/%0d", ram_diffs(), e, 2 + 2 + CLRC); else passes++;
  endtask

  task automatic test_reset_midload;
    int acc = 0;
    bit rdy;
    fill_words(8);
    kick(0, 8);
    for (int cyc = 0; cyc < 50 && acc < 3; cyc++) begin
      sif.s_valid = 1'b1; sif.s_data = words[acc];
      rdy = sif.s_ready;
      @(posedge clk);
      if (rdy) acc++;
      @(negedge clk);
    end
    sif.s_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    model_load(0, 3);
    checks++; if ({prog, cpu_clr, sif.s_ready, busy} !== 4'b0100)
      $display("FAIL midload_reset got %b want 0100", {prog, cpu_clr, sif.s_ready, busy}); else passes++;
    checks++; if (ram_diffs() !== 0 || acc !== 3)
      $display("FAIL midload_ram got %0d bad words %0d beats want 0/3", ram_diffs(), acc); else passes++;
    @(negedge clk);
    checks++; if ({prog, busy, done} !== 3'b000)
      $display("FAIL midload_idle got %b want 000", {prog, busy, done}); else passes++;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_gapped;
    test_wrap;
    test_count_zero;
    test_count_clamp;
    test_run_halt;
    test_reset_midload;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
